// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter and its client port.
//   NUM_CLIENTS_DFLT : default client count (req/gnt width)
//   state_e          : client-port FSM states
//   cnt_w()          : pending-counter width for a given saturation limit
//   is_onehot()      : exactly-one-bit-set test, also used by the arbiter
package arb_pkg;

  localparam int NUM_CLIENTS_DFLT = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  function automatic int cnt_w(input int pend_max);
    return (pend_max < 1) ? 1 : $clog2(pend_max + 1);
  endfunction

  // Callers zero-extend narrower vectors to 32 bits.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/arb_pend_counter.sv
// Per-client saturating pending-burst counter.
//   clk, rst  : clock, synchronous active-high reset
//   want      : +1 request pulse
//   dec       : -1 on the edge that ends this client's burst
//   count     : current pending bursts (0..PEND_MAX)
//   overflow  : combinational pulse when a want is dropped at saturation
module arb_pend_counter
  import arb_pkg::*;
#(
  parameter int PEND_MAX = 7,
  parameter int CNT_W    = cnt_w(PEND_MAX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             want,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic [CNT_W-1:0] count_q, count_d;

  // want and dec together cancel; dec never underflows.
  always_comb begin
    count_d  = count_q;
    overflow = 1'b0;
    if (want && !dec) begin
      if (count_q == CNT_W'(PEND_MAX)) overflow = 1'b1;
      else                             count_d  = count_q + 1'b1;
    end else if (!want && dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/arb_client_port.sv
// Requester side of the round-robin arbiter req/gnt interface.
// Counts per-client want pulses, requests while idle, and on an accepted
// one-hot grant runs a BURST_LEN-beat burst for the winner.
//   clk, rst    : clock, synchronous active-high reset
//   want        : per-client request pulses
//   gnt         : one-hot grant from the arbiter (combinational from req)
//   req         : request vector to the arbiter (only in IDLE)
//   owner       : one-hot owner of the current burst, 0 when idle
//   beat_valid  : high on each burst beat
//   last_beat   : high on the final beat
//   done        : per-client pulse on the owner's final beat
//   overflow    : per-client pulse when a want is dropped at saturation
//   gnt_err     : sticky illegal-grant flag, only with ARB_CLIENT_GNT_CHECK_EN
module arb_client_port
  import arb_pkg::*;
#(
  parameter int NUM_CLIENTS = NUM_CLIENTS_DFLT,
  parameter int BURST_LEN   = 4,
  parameter int PEND_MAX    = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CLIENTS-1:0] want,
  input  logic [NUM_CLIENTS-1:0] gnt,
  output logic [NUM_CLIENTS-1:0] req,
  output logic [NUM_CLIENTS-1:0] owner,
  output logic                   beat_valid,
  output logic                   last_beat,
  output logic [NUM_CLIENTS-1:0] done,
  output logic [NUM_CLIENTS-1:0] overflow
`ifdef ARB_CLIENT_GNT_CHECK_EN
  ,
  output logic                   gnt_err
`endif
);

  localparam int CNT_W  = cnt_w(PEND_MAX);
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  state_e                             state_q, state_d;
  logic [NUM_CLIENTS-1:0]             owner_q, owner_d;
  logic [BEAT_W-1:0]                  beat_q, beat_d;
  logic [NUM_CLIENTS-1:0][CNT_W-1:0]  pend;
  logic [NUM_CLIENTS-1:0]             pend_nz;
  logic [NUM_CLIENTS-1:0]             dec;
  logic                               gnt_ok;

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_pend
    arb_pend_counter #(.PEND_MAX(PEND_MAX), .CNT_W(CNT_W)) u_pend (
      .clk      (clk),
      .rst      (rst),
      .want     (want[g]),
      .dec      (dec[g]),
      .count    (pend[g]),
      .overflow (overflow[g])
    );
    assign pend_nz[g] = |pend[g];
  end

  // A grant is taken only if it is one-hot and names a requester.
  assign gnt_ok = is_onehot(32'(gnt)) && |(gnt & req);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    beat_d     = beat_q;
    req        = '0;
    beat_valid = 1'b0;
    last_beat  = 1'b0;
    done       = '0;
    dec        = '0;
    case (state_q)
      IDLE: begin
        req = pend_nz;
        if (gnt_ok) begin
          owner_d = gnt;
          beat_d  = BEAT_W'(BURST_LEN - 1);
          state_d = BURST;
        end
      end
      BURST: begin
        beat_valid = 1'b1;
        if (beat_q == '0) begin
          last_beat = 1'b1;
          done      = owner_q;
          dec       = owner_q;
          owner_d   = '0;
          state_d   = IDLE;
        end else begin
          beat_d = beat_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
    end
  end

  assign owner = owner_q;

`ifdef ARB_CLIENT_GNT_CHECK_EN
  logic gnt_err_q, gnt_err_d;

  // Zero/multi-hot/stray grant while requesting, or any grant mid-burst.
  always_comb begin
    gnt_err_d = gnt_err_q;
    if ((state_q == IDLE) && (req != '0) && !gnt_ok) gnt_err_d = 1'b1;
    if ((state_q == BURST) && (gnt != '0))           gnt_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) gnt_err_q <= 1'b0;
    else     gnt_err_q <= gnt_err_d;
  end

  assign gnt_err = gnt_err_q;
`endif

endmodule

// File: tb/tb_arb_client_port.sv
// Directed bench for arb_client_port: a cycle table for a single burst plus
// hand sequences for round-robin, saturation, same-edge want/dec, illegal
// grants, mid-burst reset and a BURST_LEN=1 instance.
module tb_arb_client_port;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] want = 3'b000;
  logic [2:0] gnt;
  logic [2:0] req, owner, done, overflow;
  logic       beat_valid, last_beat;

  logic [2:0] want1 = 3'b000;
  logic [2:0] req1, owner1, done1, overflow1;
  logic       beat_valid1, last_beat1;

  // 0: gnt = gnt_drv, 1: gnt = req & gnt_drv, 2: round-robin model
  int         gnt_mode = 1;
  logic [2:0] gnt_drv  = 3'b000;
  int         ptr = 0;
  int         rr_idx;

  int total = 0;
  int bad   = 0;

`ifdef ARB_CLIENT_GNT_CHECK_EN
  logic gnt_err, gnt_err1;
`endif

  always #5 clk = ~clk;

  arb_client_port #(.NUM_CLIENTS(3), .BURST_LEN(4), .PEND_MAX(7)) dut (
    .clk(clk), .rst(rst), .want(want), .gnt(gnt), .req(req), .owner(owner),
    .beat_valid(beat_valid), .last_beat(last_beat), .done(done), .overflow(overflow)
`ifdef ARB_CLIENT_GNT_CHECK_EN
    , .gnt_err(gnt_err)
`endif
  );

  arb_client_port #(.NUM_CLIENTS(3), .BURST_LEN(1), .PEND_MAX(7)) dut1 (
    .clk(clk), .rst(rst), .want(want1), .gnt(req1 & 3'b001), .req(req1), .owner(owner1),
    .beat_valid(beat_valid1), .last_beat(last_beat1), .done(done1), .overflow(overflow1)
`ifdef ARB_CLIENT_GNT_CHECK_EN
    , .gnt_err(gnt_err1)
`endif
  );

  always_comb begin
    gnt    = 3'b000;
    rr_idx = 0;
    if (gnt_mode == 0)      gnt = gnt_drv;
    else if (gnt_mode == 1) gnt = req & gnt_drv;
    else if (req != 3'b000) begin
      for (int k = 2; k >= 0; k--)
        if (req[(ptr + k) % 3]) rr_idx = (ptr + k) % 3;
      gnt[rr_idx] = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst) ptr <= 0;
    else if (gnt_mode == 2 && gnt != 3'b000) ptr <= (rr_idx + 1) % 3;
  end

  task automatic chk_v(input string n, input logic [2:0] a, input logic [2:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %b want %b @%0t", n, a, e, $time);
    end
  endtask

  task automatic chk_b(input string n, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %b want %b @%0t", n, a, e, $time);
    end
  endtask

  // Drive inputs on the falling edge, settle, then the caller samples.
  task automatic step(input logic [2:0] w);
    @(negedge clk);
    want = w;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; want = 3'b000; want1 = 3'b000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0] want;
    logic [2:0] req;
    logic [2:0] owner;
    logic       bv;
    logic       last;
    logic [2:0] done;
    logic [2:0] pend0;
  } vec_t;

  vec_t tbl[8];

  initial begin
    //            want    req     owner   bv    last  done    pend0
    tbl[0] = '{3'b001, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'd0};
    tbl[1] = '{3'b000, 3'b001, 3'b000, 1'b0, 1'b0, 3'b000, 3'd1};
    tbl[2] = '{3'b000, 3'b000, 3'b001, 1'b1, 1'b0, 3'b000, 3'd1};
    tbl[3] = '{3'b000, 3'b000, 3'b001, 1'b1, 1'b0, 3'b000, 3'd1};
    tbl[4] = '{3'b000, 3'b000, 3'b001, 1'b1, 1'b0, 3'b000, 3'd1};
    tbl[5] = '{3'b000, 3'b000, 3'b001, 1'b1, 1'b1, 3'b001, 3'd1};
    tbl[6] = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'd0};
    tbl[7] = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'd0};

    // Reset state, sampled while rst is still high after one edge.
    @(negedge clk); @(negedge clk); #1;
    chk_v("rst_req", req, 3'b000);
    chk_v("rst_owner", owner, 3'b000);
    chk_b("rst_bv", beat_valid, 1'b0);
    chk_b("rst_last", last_beat, 1'b0);
    chk_v("rst_done", done, 3'b000);
    chk_v("rst_ovf", overflow, 3'b000);
`ifdef ARB_CLIENT_GNT_CHECK_EN
    chk_b("rst_gnt_err", gnt_err, 1'b0);
`endif

    // Single burst for client 0, gnt tied to req & 001.
    gnt_mode = 1; gnt_drv = 3'b001;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].want);
      chk_v($sformatf("t%0d_req", i), req, tbl[i].req);
      chk_v($sformatf("t%0d_owner", i), owner, tbl[i].owner);
      chk_b($sformatf("t%0d_bv", i), beat_valid, tbl[i].bv);
      chk_b($sformatf("t%0d_last", i), last_beat, tbl[i].last);
      chk_v($sformatf("t%0d_done", i), done, tbl[i].done);
      chk_v($sformatf("t%0d_pend0", i), dut.pend[0], tbl[i].pend0);
    end

    // All three clients, round-robin arbiter in the loop.
    gnt_mode = 2;
    do_reset();
    step(3'b111);
    chk_v("rr_req0", req, 3'b000);
    for (int b = 0; b < 3; b++) begin
      step(3'b000);
      chk_v($sformatf("rr%0d_idle_req", b), req, 3'(3'b111 << b));
      chk_v($sformatf("rr%0d_idle_owner", b), owner, 3'b000);
      chk_b($sformatf("rr%0d_idle_bv", b), beat_valid, 1'b0);
      for (int t = 0; t < 4; t++) begin
        step(3'b000);
        chk_v($sformatf("rr%0d_b%0d_owner", b, t), owner, 3'(1 << b));
        chk_b($sformatf("rr%0d_b%0d_bv", b, t), beat_valid, 1'b1);
        chk_b($sformatf("rr%0d_b%0d_last", b, t), last_beat, t == 3);
        chk_v($sformatf("rr%0d_b%0d_done", b, t), done, (t == 3) ? 3'(1 << b) : 3'b000);
      end
    end
    step(3'b000);
    chk_v("rr_end_req", req, 3'b000);
    chk_b("rr_end_bv", beat_valid, 1'b0);

    // Saturation of client 1 with no grants.
    gnt_mode = 0; gnt_drv = 3'b000;
    do_reset();
    for (int j = 0; j < 9; j++) begin
      step(3'b010);
      chk_v($sformatf("sat_ovf%0d", j), overflow, (j >= 7) ? 3'b010 : 3'b000);
    end
    step(3'b000);
    chk_v("sat_pend1", dut.pend[1], 3'd7);
    chk_v("sat_req", req, 3'b010);
    chk_v("sat_ovf_after", overflow, 3'b000);

    // want[2] on the final beat with pend[2]==1.
    gnt_mode = 1; gnt_drv = 3'b100;
    do_reset();
    step(3'b100);
    for (int i = 0; i < 4; i++) step(3'b000);
    step(3'b100);
    chk_b("wd_last", last_beat, 1'b1);
    chk_v("wd_done", done, 3'b100);
    chk_v("wd_pend_last", dut.pend[2], 3'd1);
    chk_v("wd_ovf", overflow, 3'b000);
    step(3'b000);
    chk_v("wd_pend_after", dut.pend[2], 3'd1);
    chk_v("wd_req_after", req, 3'b100);
    chk_b("wd_bv_after", beat_valid, 1'b0);

    // Illegal grants: multi-hot then non-requesting.
    gnt_mode = 0; gnt_drv = 3'b000;
    do_reset();
    step(3'b011);
    step(3'b000);
    gnt_drv = 3'b011;
    chk_v("ill_req", req, 3'b011);
    step(3'b000);
    gnt_drv = 3'b100;
    chk_v("ill1_owner", owner, 3'b000);
    chk_b("ill1_bv", beat_valid, 1'b0);
    step(3'b000);
    gnt_drv = 3'b000;
    chk_v("ill2_owner", owner, 3'b000);
    chk_b("ill2_bv", beat_valid, 1'b0);
    chk_v("ill2_req", req, 3'b011);
`ifdef ARB_CLIENT_GNT_CHECK_EN
    chk_b("ill2_gnt_err", gnt_err, 1'b1);
    step(3'b000);
    chk_b("ill3_gnt_err", gnt_err, 1'b1);
`endif

    // Reset on the second beat of a burst.
    gnt_mode = 1; gnt_drv = 3'b001;
    do_reset();
    step(3'b011);
    step(3'b000);
    step(3'b000);
    chk_v("mr_beat1_owner", owner, 3'b001);
    step(3'b000);
    rst = 1'b1;
    chk_b("mr_beat2_bv", beat_valid, 1'b1);
    step(3'b000);
    rst = 1'b0;
    chk_b("mr_bv", beat_valid, 1'b0);
    chk_v("mr_owner", owner, 3'b000);
    chk_v("mr_done", done, 3'b000);
    chk_v("mr_req", req, 3'b000);
    chk_v("mr_pend0", dut.pend[0], 3'd0);
    chk_v("mr_pend1", dut.pend[1], 3'd0);
    chk_v("mr_pend2", dut.pend[2], 3'd0);
    step(3'b000);
    chk_v("mr_done2", done, 3'b000);
    chk_b("mr_bv2", beat_valid, 1'b0);

    // BURST_LEN=1 instance: one beat carries valid, last and done.
    do_reset();
    @(negedge clk); want1 = 3'b001; #1;
    chk_v("b1_req0", req1, 3'b000);
    @(negedge clk); want1 = 3'b000; #1;
    chk_v("b1_req1", req1, 3'b001);
    chk_b("b1_bv1", beat_valid1, 1'b0);
    @(negedge clk); #1;
    chk_b("b1_bv", beat_valid1, 1'b1);
    chk_b("b1_last", last_beat1, 1'b1);
    chk_v("b1_done", done1, 3'b001);
    chk_v("b1_owner", owner1, 3'b001);
    @(negedge clk); #1;
    chk_b("b1_bv_after", beat_valid1, 1'b0);
    chk_v("b1_req_after", req1, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
